// File: rtl/mult_seq_control.sv
// -----------------------------------------------------------------------------
// mult_seq_control
//
// Sequencer for a WIDTH-bit signed shift-add multiplier datapath (X/A/B
// registers, adder/subtractor, shift chain). Each Run issues one clear,
// then WIDTH add/subtract decisions and WIDTH shifts. The result is then held
// until Run is released.
//
// Optional feature (compile-time macro MULT_SKIP_ZERO_EN):
//   When it is defined, an ADD cycle with M=0 shifts directly and skips the
//   separate SHIFT state. Busy then lasts 1 + WIDTH + popcount(B) cycles.
//   When it is undefined, the fixed 1 + 2*WIDTH schedule is used.
//
// Parameters:
//   WIDTH         multiplier bits = number of add/shift iterations (2..16)
//
// Ports:
//   Clk           system clock, all state updates on posedge
//   Reset         asynchronous, active-low reset (0 forces IDLE)
//   Run           level-sensitive start request
//   ClearA_LoadB  load/clear request, honoured only in IDLE
//   M             current LSB of the B register (multiplier bit)
//   Clr_Ld        clear X/A, load B from switches
//   Clr_XA        clear X and A at start of a multiply
//   Add           A <= A + S
//   Sub           A <= A - S (final bit only)
//   Shift         arithmetic right shift of X:A:B
//   Busy          high from START through the last shift
//   Done          high in HOLD
// -----------------------------------------------------------------------------
module mult_seq_control #(
    parameter int WIDTH = 8
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Run,
    input  logic ClearA_LoadB,
    input  logic M,
    output logic Clr_Ld,
    output logic Clr_XA,
    output logic Add,
    output logic Sub,
    output logic Shift,
    output logic Busy,
    output logic Done
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        ADD,
        SHIFT,
        HOLD
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          last_iter;

    // The final iteration weighs the sign bit of B, so it subtracts instead of adding.
    assign last_iter = (count_q == LAST);

    // Outputs decode directly from state and inputs. A reset therefore
    // silences Add/Sub/Shift in the same cycle, without waiting for a clock edge.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        count_d = count_q;
        Clr_Ld  = 1'b0;
        Clr_XA  = 1'b0;
        Add     = 1'b0;
        Sub     = 1'b0;
        Shift   = 1'b0;
        Busy    = 1'b0;
        Done    = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Run has priority: a simultaneous load request is suppressed.
                Clr_Ld = ClearA_LoadB & ~Run;
                if (Run) state_d = START;
            end
            START: begin
                Clr_XA  = 1'b1;
                Busy    = 1'b1;
                count_d = '0;
                state_d = ADD;
            end
            ADD: begin
                Busy = 1'b1;
                if (M) begin
                    Add     = ~last_iter;
                    Sub     = last_iter;
                    state_d = SHIFT;
                end else begin
`ifdef MULT_SKIP_ZERO_EN
                    // No partial product to accumulate, so shift right away.
                    Shift   = 1'b1;
                    count_d = count_q + CW'(1);
                    state_d = last_iter ? HOLD : ADD;
`else
                    state_d = SHIFT;
`endif
                end
            end
            SHIFT: begin
                Shift   = 1'b1;
                Busy    = 1'b1;
                count_d = count_q + CW'(1);
                state_d = last_iter ? HOLD : ADD;
            end
            HOLD: begin
                Done = 1'b1;
                // Leaving only on Run=0 prevents a held Run from restarting.
                if (!Run) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The counter has one more bit than needed for WIDTH-1. It stops at WIDTH
    // after the final shift and never wraps.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q <= state_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_mult_seq_control.sv
// -----------------------------------------------------------------------------
// tb_mult_seq_control
//
// Directed testbench for mult_seq_control at WIDTH=8. A small B-register
// model feeds M back: Clr_Ld loads it from sw and Shift shifts it right.
// Expected counts are computed by hand for both builds (with and without
// MULT_SKIP_ZERO_EN).
// -----------------------------------------------------------------------------
module tb_mult_seq_control;

    logic Clk = 1'b0;
    logic Reset, Run, ClearA_LoadB, M;
    logic Clr_Ld, Clr_XA, Add, Sub, Shift, Busy, Done;

    logic [7:0] sw = 8'h00;
    logic [7:0] b_sh = 8'h00;

    int errors = 0;
    int checks = 0;

    mult_seq_control #(.WIDTH(8)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Run          (Run),
        .ClearA_LoadB (ClearA_LoadB),
        .M            (M),
        .Clr_Ld       (Clr_Ld),
        .Clr_XA       (Clr_XA),
        .Add          (Add),
        .Sub          (Sub),
        .Shift        (Shift),
        .Busy         (Busy),
        .Done         (Done)
    );

    always #5 Clk = ~Clk;

    // Minimal B register so that M follows the multiplier bits as they shift down.
    always @(posedge Clk) begin
        if (Clr_Ld)     b_sh <= sw;
        else if (Shift) b_sh <= b_sh >> 1;
    end
    assign M = b_sh[0];

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Load B, raise Run and tally outputs at each negedge until Done.
    task automatic run_op(input string tag, input logic [7:0] b, input bit toggle,
                          input int e_add, input int e_sub, input int e_shift,
                          input int e_busy);
        int n_busy = 0, n_add = 0, n_sub = 0, n_shift = 0, n_clrxa = 0;
        int n_ld = 0, n_excl = 0, sub_pos = -1;
        bit done_seen = 0;
        @(negedge Clk);
        Run = 1'b0; ClearA_LoadB = 1'b1; sw = b;
        repeat (3) @(negedge Clk);
        Run = 1'b1;   // ClearA_LoadB stays high; it must be ignored outside IDLE
        for (int c = 0; c < 60; c++) begin
            @(negedge Clk);
            if (Done) begin done_seen = 1; break; end
            if (Busy)   n_busy++;
            if (Add)    n_add++;
            if (Sub)    begin n_sub++; sub_pos = n_shift; end
            if (Shift)  n_shift++;
            if (Clr_XA) n_clrxa++;
            if (Clr_Ld) n_ld++;
            if ($countones({Clr_Ld, Clr_XA, Add, Sub, Shift}) > 1) n_excl++;
            if (toggle && n_busy == 4) Run = 1'b0;
            if (toggle && n_busy == 6) Run = 1'b1;
        end
        check({tag, " done"},    int'(done_seen), 1);
        check({tag, " busy"},    n_busy,  e_busy);
        check({tag, " add"},     n_add,   e_add);
        check({tag, " sub"},     n_sub,   e_sub);
        check({tag, " shift"},   n_shift, e_shift);
        check({tag, " clr_xa"},  n_clrxa, 1);
        check({tag, " clr_ld"},  n_ld,    0);
        check({tag, " onehot"},  n_excl,  0);
        if (e_sub != 0) check({tag, " sub_pos"}, sub_pos, 7);
    endtask

    // Expected Busy lengths depend on the build option.
`ifdef MULT_SKIP_ZERO_EN
    localparam int BUSY_07 = 12, BUSY_80 = 10, BUSY_00 = 9;
`else
    localparam int BUSY_07 = 17, BUSY_80 = 17, BUSY_00 = 17;
`endif

    initial begin
        int bad;
        // Reset with Run and ClearA_LoadB high: everything quiet, Clr_Ld gated by Run.
        Reset = 1'b0; Run = 1'b1; ClearA_LoadB = 1'b1;
        #2;
        check("rst outs", int'({Clr_Ld, Clr_XA, Add, Sub, Shift, Busy, Done}), 0);
        Run = 1'b0;
        #1;
        check("rst clr_ld", int'(Clr_Ld), 1);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        check("idle clr_ld", int'(Clr_Ld), 1);
        check("idle outs", int'({Clr_XA, Add, Sub, Shift, Busy, Done}), 0);

        // Main schedules.
        run_op("b07", 8'h07, 0, 3, 0, 8, BUSY_07);
        run_op("b80", 8'h80, 0, 0, 1, 8, BUSY_80);
        run_op("b00", 8'h00, 0, 0, 0, 8, BUSY_00);
        run_op("b5a_tog", 8'h5A, 1, 4, 0, 8, 17 - (BUSY_07 == 12 ? 4 : 0));

        // HOLD with Run kept high: no restart.
        bad = 0;
        repeat (10) begin
            @(negedge Clk);
            if (!Done || Busy || Clr_XA) bad++;
        end
        check("hold stay", bad, 0);
        Run = 1'b0;
        @(negedge Clk);
        check("hold exit done", int'(Done), 0);
        check("hold exit clr_ld", int'(Clr_Ld), 1);
        Run = 1'b1;
        @(negedge Clk);
        check("restart clr_xa", int'(Clr_XA), 1);
        check("restart busy", int'(Busy), 1);
        bad = 1;
        for (int c = 0; c < 40; c++) begin
            @(negedge Clk);
            if (Done) begin bad = 0; break; end
        end
        check("restart done", bad, 0);

        // Reset during the 5th Busy cycle.
        Run = 1'b0; sw = 8'h07;
        repeat (3) @(negedge Clk);
        Run = 1'b1;
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge Clk);
            if (Busy) bad++;
            if (bad == 5) break;
        end
        check("mid busy reached", bad, 5);
        Reset = 1'b0;
        #1;
        check("mid rst outs", int'({Clr_Ld, Clr_XA, Add, Sub, Shift, Busy, Done}), 0);
        @(negedge Clk);
        Run = 1'b0; Reset = 1'b1;
        run_op("after_rst", 8'h07, 0, 3, 0, 8, BUSY_07);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
